// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// The slave modport is the unit's view; master is the core/memory side.
interface load_store_unit_if;
   logic        req_valid_pi;
   logic        req_ready_po;
   logic        req_store_pi;
   logic [1:0]  req_size_pi;
   logic        req_unsigned_pi;
   logic [31:0] req_addr_pi;
   logic [31:0] req_wdata_pi;
   logic        resp_valid_po;
   logic        resp_ready_pi;
   logic [31:0] resp_rdata_po;
   logic        resp_err_po;
   logic        mem_load_po;
   logic        mem_store_po;
   logic [31:0] mem_addr_po;
   logic [31:0] mem_wdata_po;
   logic [31:0] mem_rdata_pi;

   modport slave (
      input  req_valid_pi, req_store_pi, req_size_pi, req_unsigned_pi,
             req_addr_pi, req_wdata_pi, resp_ready_pi, mem_rdata_pi,
      output req_ready_po, resp_valid_po, resp_rdata_po, resp_err_po,
             mem_load_po, mem_store_po, mem_addr_po, mem_wdata_po
   );

   modport master (
      output req_valid_pi, req_store_pi, req_size_pi, req_unsigned_pi,
             req_addr_pi, req_wdata_pi, resp_ready_pi, mem_rdata_pi,
      input  req_ready_po, resp_valid_po, resp_rdata_po, resp_err_po,
             mem_load_po, mem_store_po, mem_addr_po, mem_wdata_po
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time, sub-word stores done as
// read-modify-write, loads extracted and sign/zero-extended.
module load_store_unit #(
   parameter int MEM_WORDS       = 32,
   parameter bit ERR_ON_MISALIGN = 1'b1
) (
   input  logic               clk_pi,
   input  logic               reset_n_pi,
   load_store_unit_if.slave   bus
);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int AW    = IDX_W + 2;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_STORE  = 3'd2;
   localparam logic [2:0] S_RMW_RD = 3'd3;
   localparam logic [2:0] S_RMW_WR = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   logic [2:0]    state_reg;
   logic          store_reg;
   logic [1:0]    size_reg;
   logic          unsigned_reg;
   logic [AW-1:0] addr_reg;
   logic [31:0]   wdata_reg;
   logic [31:0]   rdata_reg;
   logic [31:0]   rmw_word_reg;
   logic          err_reg;

   logic [AW-1:0] req_addr_low;
   logic [AW-1:0] aligned_addr;
   logic          misalign;
   logic          req_err;
   logic [31:0]   byte_shift;
   logic [15:0]   half_sel;
   logic [31:0]   load_ext;
   logic [31:0]   merged_word;
   logic          mem_active;

   // Only the address bits that reach the word index and lane are kept.
   assign req_addr_low = bus.req_addr_pi[AW-1:0];

   always_comb begin
      misalign = 1'b0;
      aligned_addr = req_addr_low;
      case (bus.req_size_pi)
         2'b01: begin
            misalign = req_addr_low[0];
            aligned_addr = {req_addr_low[AW-1:1], 1'b0};
         end
         2'b10: begin
            misalign = (req_addr_low[1:0] != 2'b00);
            aligned_addr = {req_addr_low[AW-1:2], 2'b00};
         end
         default: ;
      endcase
      req_err = (bus.req_size_pi == 2'b11) || (ERR_ON_MISALIGN && misalign);
   end

   always_comb begin
      byte_shift = bus.mem_rdata_pi >> {addr_reg[1:0], 3'b000};
      half_sel = addr_reg[1] ? bus.mem_rdata_pi[31:16] : bus.mem_rdata_pi[15:0];
      case (size_reg)
         2'b00:   load_ext = {{24{~unsigned_reg & byte_shift[7]}}, byte_shift[7:0]};
         2'b01:   load_ext = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
         default: load_ext = bus.mem_rdata_pi;
      endcase
   end

   // Lane merge for read-modify-write: each byte lane picks new or old data.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic lane_hit;
         assign lane_hit = ((size_reg == 2'b00) && (addr_reg[1:0] == 2'(gi))) ||
                           ((size_reg == 2'b01) && (addr_reg[1] == 1'(gi / 2)));
         if (gi % 2 == 1) begin : g_odd
            assign merged_word[gi*8 +: 8] = !lane_hit ? rmw_word_reg[gi*8 +: 8] :
                                            (size_reg == 2'b01) ? wdata_reg[15:8] :
                                                                   wdata_reg[7:0];
         end else begin : g_even
            assign merged_word[gi*8 +: 8] = lane_hit ? wdata_reg[7:0] :
                                                       rmw_word_reg[gi*8 +: 8];
         end
      end
   endgenerate

   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         state_reg    <= S_IDLE;
         store_reg    <= 1'b0;
         size_reg     <= 2'b00;
         unsigned_reg <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= 32'd0;
         rdata_reg    <= 32'd0;
         rmw_word_reg <= 32'd0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.req_valid_pi) begin
                  store_reg    <= bus.req_store_pi;
                  size_reg     <= bus.req_size_pi;
                  unsigned_reg <= bus.req_unsigned_pi;
                  addr_reg     <= aligned_addr;
                  wdata_reg    <= bus.req_wdata_pi;
                  rdata_reg    <= 32'd0;
                  rmw_word_reg <= 32'd0;
                  err_reg      <= req_err;
                  if (req_err)
                     state_reg <= S_RESP;
                  else if (!bus.req_store_pi)
                     state_reg <= S_LOAD;
                  else if (bus.req_size_pi == 2'b10)
                     state_reg <= S_STORE;
                  else
                     state_reg <= S_RMW_RD;
               end
            end
            S_LOAD: begin
               rdata_reg <= load_ext;
               state_reg <= S_RESP;
            end
            S_STORE:  state_reg <= S_RESP;
            S_RMW_RD: begin
               rmw_word_reg <= bus.mem_rdata_pi;
               state_reg    <= S_RMW_WR;
            end
            S_RMW_WR: state_reg <= S_RESP;
            S_RESP: begin
               if (bus.resp_ready_pi)
                  state_reg <= S_IDLE;
            end
            default:  state_reg <= S_IDLE;
         endcase
      end
   end

   // Memory side is decoded purely from state and captured registers.
   assign mem_active        = (state_reg == S_LOAD) || (state_reg == S_STORE) ||
                              (state_reg == S_RMW_RD) || (state_reg == S_RMW_WR);
   assign bus.mem_load_po   = (state_reg == S_LOAD) || (state_reg == S_RMW_RD);
   assign bus.mem_store_po  = (state_reg == S_STORE) || (state_reg == S_RMW_WR);
   assign bus.mem_addr_po   = mem_active ? {{(32-IDX_W){1'b0}}, addr_reg[AW-1:2]} : 32'd0;
   assign bus.mem_wdata_po  = (state_reg == S_STORE)  ? wdata_reg :
                              (state_reg == S_RMW_WR) ? merged_word : 32'd0;

   assign bus.req_ready_po  = reset_n_pi && (state_reg == S_IDLE);
   assign bus.resp_valid_po = (state_reg == S_RESP);
   assign bus.resp_rdata_po = (state_reg == S_RESP) ? rdata_reg : 32'd0;
   assign bus.resp_err_po   = (state_reg == S_RESP) && err_reg;

   // store_reg is kept for debug visibility of the captured request.
   logic unused_ok;
   assign unused_ok = store_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word behavioural memory.
module tb_load_store_unit;
   logic clk;
   logic rst_n;
   logic [31:0] dmem [32];
   int vectors;
   int miscompares;

   load_store_unit_if bus();

   load_store_unit #(.MEM_WORDS(32), .ERR_ON_MISALIGN(1'b1)) dut (
      .clk_pi(clk),
      .reset_n_pi(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rdata_pi = dmem[bus.mem_addr_po[4:0]];
   always @(posedge clk)
      if (bus.mem_store_po) dmem[bus.mem_addr_po[4:0]] <= bus.mem_wdata_po;

   task automatic transact(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int nld, output int nst, output logic [31:0] maddr);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.req_ready_po && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      bus.req_valid_pi = 1'b1; bus.req_store_pi = st; bus.req_size_pi = sz;
      bus.req_unsigned_pi = uns; bus.req_addr_pi = a; bus.req_wdata_pi = wd;
      @(posedge clk);
      #1 bus.req_valid_pi = 1'b0;
      lat = 0; nld = 0; nst = 0; maddr = 32'd0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.mem_load_po) begin nld++; maddr = bus.mem_addr_po; end
         if (bus.mem_store_po) begin nst++; maddr = bus.mem_addr_po; end
      end while (!bus.resp_valid_po && lat < 10);
      rd = bus.resp_rdata_po;
      er = bus.resp_err_po;
      $display("txn st=%0b sz=%0d uns=%0b addr=%h wd=%h -> rdata=%h err=%0b lat=%0d ld=%0d st=%0d maddr=%0d",
               st, sz, uns, a, wd, rd, er, lat, nld, nst, maddr);
      bus.resp_ready_pi = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready_pi = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      vectors++; if (bus.req_ready_po !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b exp 0", bus.req_ready_po); end
      vectors++; if (bus.resp_valid_po !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got %b exp 0", bus.resp_valid_po); end
      vectors++; if ({bus.mem_load_po, bus.mem_store_po, bus.mem_addr_po, bus.mem_wdata_po} !== 66'd0) begin
         miscompares++; $display("FAIL rst_mem got %b %b %h %h exp zeros", bus.mem_load_po, bus.mem_store_po, bus.mem_addr_po, bus.mem_wdata_po); end
      vectors++; if ({bus.resp_rdata_po, bus.resp_err_po} !== 33'd0) begin
         miscompares++; $display("FAIL rst_resp got %h %b exp 0", bus.resp_rdata_po, bus.resp_err_po); end
      #20 rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (bus.req_ready_po !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after got %b exp 1", bus.req_ready_po); end
      $display("reset checked");
   endtask

   task automatic test_word_load();
      logic [31:0] rd, ma; logic er; int lat, nld, nst;
      transact(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (rd !== 32'h69) begin miscompares++; $display("FAIL wl_rdata got %h exp 00000069", rd); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL wl_err got %b exp 0", er); end
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wl_lat got %0d exp 2", lat); end
      vectors++; if (nld !== 1 || nst !== 0) begin miscompares++; $display("FAIL wl_strobes got ld=%0d st=%0d exp 1 0", nld, nst); end
      vectors++; if (ma !== 32'd5) begin miscompares++; $display("FAIL wl_addr got %0d exp 5", ma); end
      transact(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (rd !== 32'h64 || ma !== 32'd0) begin miscompares++; $display("FAIL wrap got %h addr %0d exp 00000064 addr 0", rd, ma); end
   endtask

   task automatic test_subword_store();
      logic [31:0] rd, ma; logic er; int lat, nld, nst;
      transact(1'b1, 2'b00, 1'b0, 32'h19, 32'h123456AB, rd, er, lat, nld, nst, ma);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL bs_lat got %0d exp 3", lat); end
      vectors++; if (nld !== 1 || nst !== 1 || ma !== 32'd6) begin miscompares++; $display("FAIL bs_strobes got ld=%0d st=%0d addr=%0d exp 1 1 6", nld, nst, ma); end
      vectors++; if (rd !== 32'd0 || er !== 1'b0) begin miscompares++; $display("FAIL bs_resp got %h %b exp 0 0", rd, er); end
      vectors++; if (dmem[6] !== 32'h0000AB6A) begin miscompares++; $display("FAIL bs_mem got %h exp 0000AB6A", dmem[6]); end
      transact(1'b0, 2'b01, 1'b1, 32'h18, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (rd !== 32'h0000AB6A) begin miscompares++; $display("FAIL hlu got %h exp 0000AB6A", rd); end
      transact(1'b0, 2'b01, 1'b0, 32'h1A, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL hls got %h exp 00000000", rd); end
      transact(1'b1, 2'b00, 1'b0, 32'h1C, 32'h000000F0, rd, er, lat, nld, nst, ma);
      vectors++; if (dmem[7] !== 32'h000000F0) begin miscompares++; $display("FAIL bs2_mem got %h exp 000000F0", dmem[7]); end
      transact(1'b0, 2'b00, 1'b0, 32'h1C, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (rd !== 32'hFFFFFFF0) begin miscompares++; $display("FAIL bls got %h exp FFFFFFF0", rd); end
      transact(1'b0, 2'b00, 1'b1, 32'h1C, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (rd !== 32'h000000F0) begin miscompares++; $display("FAIL blu got %h exp 000000F0", rd); end
      transact(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, rd, er, lat, nld, nst, ma);
      vectors++; if (dmem[3] !== 32'hBEEF0067) begin miscompares++; $display("FAIL hs_mem got %h exp BEEF0067", dmem[3]); end
      transact(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, rd, er, lat, nld, nst, ma);
      vectors++; if (lat !== 2 || nst !== 1 || nld !== 0 || dmem[4] !== 32'hCAFEF00D) begin
         miscompares++; $display("FAIL ws got lat=%0d ld=%0d st=%0d mem=%h exp 2 0 1 CAFEF00D", lat, nld, nst, dmem[4]); end
   endtask

   task automatic test_misalign();
      logic [31:0] rd, ma; logic er; int lat, nld, nst;
      transact(1'b0, 2'b01, 1'b0, 32'h21, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin miscompares++; $display("FAIL mis_hl got err=%b rd=%h lat=%0d exp 1 0 1", er, rd, lat); end
      vectors++; if (nld !== 0 || nst !== 0) begin miscompares++; $display("FAIL mis_hl_strobes got %0d %0d exp 0 0", nld, nst); end
      transact(1'b1, 2'b10, 1'b0, 32'h22, 32'h11111111, rd, er, lat, nld, nst, ma);
      vectors++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || nld !== 0 || nst !== 0) begin
         miscompares++; $display("FAIL mis_ws got err=%b rd=%h lat=%0d ld=%0d st=%0d exp 1 0 1 0 0", er, rd, lat, nld, nst); end
      vectors++; if (dmem[8] !== 32'd108) begin miscompares++; $display("FAIL mis_ws_mem got %h exp 0000006C", dmem[8]); end
      transact(1'b0, 2'b11, 1'b0, 32'h00, 32'd0, rd, er, lat, nld, nst, ma);
      vectors++; if (er !== 1'b1 || lat !== 1 || nld !== 0) begin miscompares++; $display("FAIL rsv got err=%b lat=%0d ld=%0d exp 1 1 0", er, lat, nld); end
   endtask

   task automatic test_backpressure();
      int guard;
      logic side_strobe;
      side_strobe = 1'b0;
      @(negedge clk);
      bus.req_valid_pi = 1'b1; bus.req_store_pi = 1'b0; bus.req_size_pi = 2'b10;
      bus.req_unsigned_pi = 1'b0; bus.req_addr_pi = 32'h14; bus.req_wdata_pi = 32'd0;
      @(posedge clk);
      #1 bus.req_store_pi = 1'b1; bus.req_wdata_pi = 32'hDEADBEEF;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!bus.resp_valid_po && guard < 10);
      for (int k = 0; k < 3; k++) begin
         vectors++; if (bus.resp_valid_po !== 1'b1 || bus.resp_rdata_po !== 32'h69) begin
            miscompares++; $display("FAIL bp_hold%0d got v=%b rd=%h exp 1 00000069", k, bus.resp_valid_po, bus.resp_rdata_po); end
         vectors++; if (bus.req_ready_po !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d got %b exp 0", k, bus.req_ready_po); end
         if (bus.mem_store_po || bus.mem_load_po) side_strobe = 1'b1;
         @(negedge clk);
      end
      $display("txn backpressured word load held 3 cycles");
      bus.req_valid_pi = 1'b0;
      bus.resp_ready_pi = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready_pi = 1'b0;
      @(negedge clk);
      vectors++; if (bus.resp_valid_po !== 1'b0 || bus.req_ready_po !== 1'b1) begin
         miscompares++; $display("FAIL bp_idle got v=%b rdy=%b exp 0 1", bus.resp_valid_po, bus.req_ready_po); end
      vectors++; if (side_strobe !== 1'b0 || dmem[5] !== 32'h69) begin
         miscompares++; $display("FAIL bp_ignored got strobe=%b mem=%h exp 0 00000069", side_strobe, dmem[5]); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.req_valid_pi = 1'b1; bus.req_store_pi = 1'b1; bus.req_size_pi = 2'b00;
      bus.req_unsigned_pi = 1'b0; bus.req_addr_pi = 32'h08; bus.req_wdata_pi = 32'h55;
      @(posedge clk);
      #1 bus.req_valid_pi = 1'b0;
      @(negedge clk);
      vectors++; if (bus.mem_load_po !== 1'b1) begin miscompares++; $display("FAIL rm_rd got %b exp 1", bus.mem_load_po); end
      #1 rst_n = 1'b0;
      #1;
      vectors++; if ({bus.mem_load_po, bus.mem_store_po, bus.mem_addr_po, bus.mem_wdata_po, bus.req_ready_po, bus.resp_valid_po} !== 68'd0) begin
         miscompares++; $display("FAIL rm_async got ld=%b st=%b a=%h wd=%h rdy=%b v=%b exp zeros", bus.mem_load_po, bus.mem_store_po,
                                 bus.mem_addr_po, bus.mem_wdata_po, bus.req_ready_po, bus.resp_valid_po); end
      @(posedge clk);
      #1;
      vectors++; if (bus.mem_store_po !== 1'b0) begin miscompares++; $display("FAIL rm_store got %b exp 0", bus.mem_store_po); end
      @(negedge clk);
      rst_n = 1'b1;
      vectors++; if (dmem[2] !== 32'd102) begin miscompares++; $display("FAIL rm_mem got %h exp 00000066", dmem[2]); end
      @(negedge clk);
      vectors++; if (bus.req_ready_po !== 1'b1) begin miscompares++; $display("FAIL rm_ready got %b exp 1", bus.req_ready_po); end
      $display("txn reset during sub-word store checked");
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      for (int i = 0; i < 32; i++) dmem[i] = 32'(100 + i);
      rst_n = 1'b0;
      bus.req_valid_pi = 1'b0; bus.req_store_pi = 1'b0; bus.req_size_pi = 2'b00;
      bus.req_unsigned_pi = 1'b0; bus.req_addr_pi = 32'd0; bus.req_wdata_pi = 32'd0;
      bus.resp_ready_pi = 1'b0;
      test_reset();
      test_word_load();
      test_subword_store();
      test_misalign();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
